// File: rtl/qmult_sched_if.sv
// qmult_sched_if: requester-side bundle of the shared-multiplier scheduler.
//
// Handshake (one comment, applies to every requester i):
//   req[i] is a level request. The requester raises it with a_bus/b_bus slice
//   i valid and holds it until done[i] pulses. Operands are sampled only on the
//   grant edge. done[i] is a one-cycle pulse with result/ovr valid in that same
//   cycle. A requester that keeps req[i] high after done[i] is treated as
//   issuing a new request.
//
// Signals:
//   req        requester -> scheduler  per-requester request level
//   a_bus      requester -> scheduler  multiplicand i at [i*N +: N]
//   b_bus      requester -> scheduler  multiplier i at [i*N +: N]
//   done       scheduler -> requester  one-hot completion pulse
//   result     scheduler -> requester  registered sign-magnitude product
//   ovr        scheduler -> requester  registered overflow flag
//   gnt_id     scheduler -> requester  index being served
//   busy       scheduler -> requester  operation in flight
//   state_dbg  scheduler -> observer   raw FSM state encoding
interface qmult_sched_if #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] a_bus;
    logic [NREQ*N-1:0] b_bus;
    logic [NREQ-1:0]   done;
    logic [N-1:0]      result;
    logic              ovr;
    logic [IDW-1:0]    gnt_id;
    logic              busy;
    logic [1:0]        state_dbg;

    modport master (
        output req, a_bus, b_bus,
        input  done, result, ovr, gnt_id, busy, state_dbg
    );

    modport slave (
        input  req, a_bus, b_bus,
        output done, result, ovr, gnt_id, busy, state_dbg
    );
endinterface

// File: rtl/qmult_sched.sv
// qmult_sched: round-robin scheduler sharing one sign-magnitude fixed-point
// multiplier (qmult) among NREQ requesters.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    qmult_sched_if.slave (req/a_bus/b_bus in; done/result/ovr/gnt_id/
//          busy/state_dbg out)
//
// Flow: S_IDLE picks a winner and latches its operands, S_MUL registers the
// product, S_DONE pulses done[gnt_id] and advances the round-robin pointer.

// qmult: combinational sign-magnitude multiply with Q fractional bits.
// Magnitude is truncated; discarded high product bits raise ovr (no saturation).
module qmult #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y,
    output logic         ovr
);
    logic [2*N-3:0] p;

    assign p   = (2*N-2)'(a[N-2:0]) * (2*N-2)'(b[N-2:0]);
    // Sign is the XOR even for zero magnitude; -0 is intentionally kept.
    assign y   = {a[N-1] ^ b[N-1], (N-1)'(p >> Q)};
    assign ovr = |(p >> (N-1+Q));
endmodule

module qmult_sched #(
    parameter int N    = 32,
    parameter int Q    = 15,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    qmult_sched_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] gnt_r;
    logic [N-1:0]   op_a, op_b;
    logic [N-1:0]   result_r;
    logic           ovr_r;
    logic [N-1:0]   mul_y;
    logic           mul_ovr;

    logic           win_valid;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] cand;
    logic           load_op, load_res, advance_ptr;

    // Round-robin search: first set req bit at ptr, ptr+1, ... (mod NREQ).
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!win_valid && bus.req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        load_op     = 1'b0;
        load_res    = 1'b0;
        advance_ptr = 1'b0;
        case (state)
            S_IDLE: begin
                if (win_valid) begin
                    load_op    = 1'b1;
                    state_next = S_MUL;
                end
            end
            S_MUL: begin
                load_res   = 1'b1;
                state_next = S_DONE;
            end
            S_DONE: begin
                advance_ptr = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            gnt_r    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_r <= '0;
            ovr_r    <= 1'b0;
        end else begin
            if (load_op) begin
                op_a  <= bus.a_bus[win_id*N +: N];
                op_b  <= bus.b_bus[win_id*N +: N];
                gnt_r <= win_id;
            end
            if (load_res) begin
                result_r <= mul_y;
                ovr_r    <= mul_ovr;
            end
            // Pointer moves past the requester just served, wrapping at NREQ-1.
            if (advance_ptr) begin
                ptr <= (gnt_r == IDW'(NREQ-1)) ? '0 : gnt_r + 1'b1;
            end
        end
    end

    // The multiplier only ever sees the latched operands, so requesters may
    // change their buses once granted.
    qmult #(.N(N), .Q(Q)) u_qmult (
        .a   (op_a),
        .b   (op_b),
        .y   (mul_y),
        .ovr (mul_ovr)
    );

    assign bus.done      = (state == S_DONE) ? (NREQ'(1) << gnt_r) : '0;
    assign bus.result    = result_r;
    assign bus.ovr       = ovr_r;
    assign bus.gnt_id    = gnt_r;
    assign bus.busy      = (state != S_IDLE);
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_qmult_sched.sv
module tb_qmult_sched;
    localparam int N    = 32;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int EW   = IDW + N + 1;

    logic clk;
    logic rst_n;
    int   cyc;

    qmult_sched_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

    qmult_sched #(.N(N), .Q(15), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            done_cyc_q[$];
    int            total_cnt;
    int            pass_cnt;
    int            done_total;
    int            serve_left[NREQ];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        logic [EW-1:0]  e;
        logic [IDW-1:0] e_id;
        if (rst_n && bus.done != '0) begin
            done_total++;
            done_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_done: got done=%b, expected no pulse", bus.done);
            end else begin
                e    = exp_q.pop_front();
                e_id = e[EW-1 -: IDW];
                check("done_vec", 64'(bus.done), 64'(NREQ'(1) << e_id));
                check("gnt_id",   64'(bus.gnt_id), 64'(e_id));
                check("result",   64'(bus.result), 64'(e[N:1]));
                check("ovr",      64'(bus.ovr), 64'(e[0]));
            end
        end
    end

    // Requester model: drops req[i] after its remaining grant count runs out.
    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (bus.done[i] && serve_left[i] > 0) begin
                serve_left[i]--;
                if (serve_left[i] == 0) bus.req[i] = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) serve_left[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_ops(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.a_bus[id*N +: N] = a;
        bus.b_bus[id*N +: N] = b;
    endtask

    task automatic expect_res(input int id, input logic [N-1:0] r, input logic o);
        exp_q.push_back({IDW'(id), r, o});
    endtask

    // Issue one request from id on a falling edge; optionally record expectation.
    task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] r, input logic o, input bit push);
        @(negedge clk);
        #1;
        set_ops(id, a, b);
        if (push) expect_res(id, r, o);
        serve_left[id] = 1;
        bus.req[id]    = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= budget) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    task automatic load_four();
        set_ops(0, 32'h0000_8000, 32'h0001_8000);
        set_ops(1, 32'h8001_0000, 32'h8001_0000);
        set_ops(2, 32'h0000_2000, 32'h8000_8000);
        set_ops(3, 32'h0000_0001, 32'h0000_0001);
        expect_res(0, 32'h0001_8000, 1'b0);
        expect_res(1, 32'h0002_0000, 1'b0);
        expect_res(2, 32'h8000_2000, 1'b0);
        expect_res(3, 32'h0000_0000, 1'b0);
        for (int i = 0; i < NREQ; i++) serve_left[i] = 1;
        bus.req = '1;
    endtask

    task automatic check_spacing(input string name);
        for (int i = 1; i < done_cyc_q.size(); i++)
            check(name, 64'(done_cyc_q[i] - done_cyc_q[i-1]), 64'd3);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int base;
        cyc        = 0;
        total_cnt  = 0;
        pass_cnt   = 0;
        done_total = 0;
        bus.req    = '0;
        bus.a_bus  = '0;
        bus.b_bus  = '0;
        do_reset();
        #1;
        check("rst_done",   64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_ovr",    64'(bus.ovr), 64'd0);
        check("rst_gnt_id", 64'(bus.gnt_id), 64'd0);
        check("rst_busy",   64'(bus.busy), 64'd0);

        // 1.5 * 2.0 with latency measurement
        issue(0, 32'h0000_C000, 32'h0001_0000, 32'h0001_8000, 1'b0, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            #1;
            lat++;
        end while (!bus.done[0] && lat < 10);
        check("latency", 64'(lat), 64'd2);
        wait_drain(20);

        // -0.5 * 0.5 and -0 preservation
        issue(2, 32'h8000_4000, 32'h0000_4000, 32'h8000_2000, 1'b0, 1'b1);
        wait_drain(20);
        issue(2, 32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b1);
        wait_drain(20);

        // overflow with wrapped magnitude
        issue(1, 32'h4000_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 1'b1);
        wait_drain(20);

        // all four from reset, order 0..3, 3 cycles apart
        do_reset();
        @(negedge clk);
        #1;
        done_cyc_q.delete();
        load_four();
        wait_drain(60);
        check("four_count", 64'(done_cyc_q.size()), 64'd4);
        check_spacing("four_spacing");

        // req[0] and req[3] held for two grants each -> 0,3,0,3
        @(negedge clk);
        #1;
        done_cyc_q.delete();
        set_ops(0, 32'h0001_0000, 32'h0000_C000);
        set_ops(3, 32'h0000_4000, 32'h8000_4000);
        expect_res(0, 32'h0001_8000, 1'b0);
        expect_res(3, 32'h8000_2000, 1'b0);
        expect_res(0, 32'h0001_8000, 1'b0);
        expect_res(3, 32'h8000_2000, 1'b0);
        serve_left[0] = 2;
        serve_left[3] = 2;
        bus.req = 4'b1001;
        wait_drain(60);
        check("alt_count", 64'(done_cyc_q.size()), 64'd4);
        check_spacing("alt_spacing");

        // reset during S_MUL aborts the operation
        issue(1, 32'h0001_0000, 32'h0001_0000, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        base  = done_total;
        rst_n = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) serve_left[i] = 0;
        #1;
        check("abort_busy",   64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_ovr",    64'(bus.ovr), 64'd0);
        check("abort_done",   64'(bus.done), 64'd0);
        check("abort_gnt",    64'(bus.gnt_id), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("abort_no_done", 64'(done_total), 64'(base));
        load_four();
        wait_drain(60);

        // operands changed and req dropped after grant
        issue(2, 32'h0001_8000, 32'h0001_8000, 32'h0004_8000, 1'b0, 1'b1);
        base = done_total;
        @(negedge clk);
        #1;
        set_ops(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        bus.req[2] = 1'b0;
        wait_drain(20);
        repeat (4) @(negedge clk);
        #1;
        check("drop_one_done", 64'(done_total - base), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end
endmodule
